// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder: one decimal digit per clock, least-significant first,
// with start/busy/done handshake and invalid-digit flagging.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic [W-1:0]  work_reg;
  logic          err_pend_reg;
  logic [W-1:0]  sum_reg;
  logic          cout_reg;
  logic          err_reg;

  // Per-digit validity of the operands presented at the accepting edge.
  logic [DIGITS-1:0] dig_bad;
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig_chk
      assign dig_bad[gi] = (a[4*gi +: 4] > 4'd9) | (b[4*gi +: 4] > 4'd9);
    end
  endgenerate

  logic [CW+1:0] base;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [4:0]    raw;
  logic          fix;
  logic [3:0]    res;
  logic [W-1:0]  work_next;

  always_comb begin
    base      = {cnt_reg, 2'b00};
    a_dig     = a_reg[base +: 4];
    b_dig     = b_reg[base +: 4];
    raw       = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_reg};
    // raw >= 10 needs the +6 decimal correction and produces a carry
    fix       = raw[4] | (raw[3] & raw[2]) | (raw[3] & raw[1]);
    res       = fix ? (raw[3:0] + 4'd6) : raw[3:0];
    work_next = work_reg;
    work_next[base +: 4] = res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      work_reg     <= '0;
      err_pend_reg <= 1'b0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else if (state_reg == ADD) begin
      work_reg  <= work_next;
      carry_reg <= fix;
      if (cnt_reg == LAST) begin
        state_reg <= FIN;
        sum_reg   <= work_next;
        cout_reg  <= fix;
        err_reg   <= err_pend_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end else if (start) begin
      // IDLE and FIN both accept a new operation
      state_reg    <= ADD;
      cnt_reg      <= '0;
      a_reg        <= a;
      b_reg        <= b;
      carry_reg    <= cin;
      err_pend_reg <= |dig_bad;
    end else begin
      state_reg <= IDLE;
    end
  end

  assign busy = (state_reg == ADD);
  assign done = (state_reg == FIN);
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: vector table, single-digit sweep against a
// decimal model, and handshake corner cases, all checked via a scoreboard.
module tb_bcd_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        e;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        e;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  int   done_cycs[$];
  vec_t vecs[8];

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Decimal reference: convert to integers, add, convert back.
  function automatic exp_t ref_add(input logic [15:0] x, input logic [15:0] y, input logic ci);
    exp_t r;
    int vx, vy, t;
    vx = 0;
    vy = 0;
    for (int i = 3; i >= 0; i--) begin
      vx = vx * 10 + int'(x[4*i +: 4]);
      vy = vy * 10 + int'(y[4*i +: 4]);
    end
    t   = vx + vy + int'(ci);
    r.c = (t >= 10000);
    t   = t % 10000;
    for (int i = 0; i < 4; i++) begin
      r.s[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    r.e = 1'b0;
    return r;
  endfunction

  // Scoreboard consumer: compares every DONE against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy | done) check("busy_done_exclusive", 32'(busy & done), 32'd0);
        if (done) begin
          done_cycs.push_back(cyc);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got DONE with sum %h, expected no DONE", sum);
          end else begin
            e = sb.pop_front();
            check("sum", 32'(sum), 32'(e.s));
            check("cout", 32'(cout), 32'(e.c));
            check("err", 32'(err), 32'(e.e));
          end
        end
      end
    end
  end

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input exp_t ex);
    int lat, bcnt;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    sb.push_back(ex);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    for (int off = 0; off < 10; off++) begin
      if (off > 0) @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = off + 1;
        break;
      end
    end
    if (lat == 0) sb.delete();
    check("latency", 32'(lat), 32'd5);
    check("busy_cycles", 32'(bcnt), 32'd4);
    $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d lat=%0d", ta, tb, tc, sum, cout, err, lat);
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
    check("sum_hold", 32'(sum), 32'(ex.s));
  endtask

  initial begin
    exp_t ex;
    int   got;
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ex;
    int   got;
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h00A5, 16'h0001, 1'b0, 16'h0106, 1'b0, 1'b1};
    vecs[5] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[6] = '{16'h0500, 16'h0500, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[7] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      ex.s = vecs[i].s; ex.c = vecs[i].c; ex.e = vecs[i].e;
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, ex);
    end

    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 10; y++)
        for (int c = 0; c < 2; c++)
          do_op({12'h000, 4'(x)}, {12'h000, 4'(y)}, 1'(c),
                ref_add({12'h000, 4'(x)}, {12'h000, 4'(y)}, 1'(c)));

    // START re-pulsed during ADD with other operands must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    sb.push_back(ref_add(16'h1234, 16'h5678, 1'b0));
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (got == 0) sb.delete();
    check("add_start_ignored_done", 32'(got), 32'd1);
    $display("op start-during-add -> sum=%h cout=%0d", sum, cout);
    repeat (8) @(negedge clk);

    // START held through FIN: three back-to-back results, five cycles apart.
    done_cycs.delete();
    ex = ref_add(16'h4321, 16'h1111, 1'b1);
    repeat (3) sb.push_back(ex);
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_done_count", 32'(done_cycs.size()), 32'd3);
    if (done_cycs.size() == 3) begin
      check("b2b_interval_1", 32'(done_cycs[1] - done_cycs[0]), 32'd5);
      check("b2b_interval_2", 32'(done_cycs[2] - done_cycs[1]), 32'd5);
    end
    $display("op back-to-back x3 -> sum=%h dones=%0d", sum, done_cycs.size());

    // Reset two edges into ADD: outputs clear at once, no DONE follows.
    @(negedge clk);
    a = 16'h2222; b = 16'h3333; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    $display("op reset-abort -> busy=%0d sum=%h", busy, sum);
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    do_op(16'h2222, 16'h3333, 1'b0, ref_add(16'h2222, 16'h3333, 1'b0));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
